dut_bus_master: RTL

- Upstream driver for the 1-bit register-mapped compute slave (3-bit address, separate write/read en/rdy method ports).
- Accepts operand pairs (a, b) on a valid/ready stream and writes them into the slave's A and B queues.
- Polls the slave for the result Y, reads it, and presents it on an output valid/ready stream.
- Sits between the test/stimulus source and the slave; its bus ports connect one-to-one to the slave's write_* and read_* ports.

---
 rtl/dut_bus_pkg.sv | 26 ++
 rtl/dut_bus_port.sv | 57 +++++
 rtl/dut_bus_master.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/dut_bus_pkg.sv
// Shared definitions for the register-mapped slave bus master.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package dut_bus_pkg;

    // Slave register map
    localparam logic [2:0] ADDR_A_STATUS = 3'd0;  // read: 1 = A queue has space
    localparam logic [2:0] ADDR_A_DATA   = 3'd1;  // write
    localparam logic [2:0] ADDR_B_STATUS = 3'd2;  // read: 1 = B queue has space
    localparam logic [2:0] ADDR_B_DATA   = 3'd3;  // write
    localparam logic [2:0] ADDR_Y_STATUS = 3'd4;  // read: 1 = result available
    localparam logic [2:0] ADDR_Y_OUTPUT = 3'd5;  // read: pops the result

    typedef enum logic [3:0] {
        IDLE,
        POLL_A,
        WR_A,
        POLL_B,
        WR_B,
        POLL_Y,
        RD_Y,
        OUT,
        ERR
    } state_t;

endpackage

// File: rtl/dut_bus_port.sv
// Single-access strobe generator: holds one registered read or write request toward the slave.
// Latency: request/address/data registered one cycle after the FSM selects them.
// Backpressure: a pending request waits (strobe gated low) until the slave's rdy for that direction is high.
//
// Ports:
//   clk, rst                      clock, async active-high reset
//   wr_req_next, rd_req_next      request to hold during the next cycle (at most one set)
//   addr_next, data_next          address/data for that request
//   write_rdy, read_rdy           slave method readiness
//   write_address/data/en         slave write port
//   read_address/en               slave read port
module dut_bus_port (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_req_next,
    input  logic       rd_req_next,
    input  logic [2:0] addr_next,
    input  logic       data_next,
    input  logic       write_rdy,
    input  logic       read_rdy,
    output logic [2:0] write_address,
    output logic       write_data,
    output logic       write_en,
    output logic [2:0] read_address,
    output logic       read_en
);

    logic wr_req;
    logic rd_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_req        <= 1'b0;
            rd_req        <= 1'b0;
            write_address <= '0;
            write_data    <= 1'b0;
            read_address  <= '0;
        end else begin
            wr_req <= wr_req_next;
            rd_req <= rd_req_next;
            if (wr_req_next) begin
                write_address <= addr_next;
                write_data    <= data_next;
            end
            if (rd_req_next) begin
                read_address <= addr_next;
            end
        end
    end

    // The strobe is the registered request qualified by the slave's rdy in the
    // same cycle, so an access never fires against a slave that cannot take it.
    // Address and data come straight from flops and are stable for the strobe.
    assign write_en = wr_req & write_rdy;
    assign read_en  = rd_req & read_rdy;

endmodule

// File: rtl/dut_bus_master.sv
// Bus master: takes (a,b) pairs, writes them to the slave A/B queues, polls and reads Y, returns it.
// Latency: 7 cycles from accept to out_valid with an always-ready slave whose status reads return 1.
// Backpressure: in_ready only in IDLE; result held on out_valid until out_ready; slave rdy stalls accesses.
//
// Ports:
//   CLK, RST_N (active-high async reset)
//   in_valid/in_ready/in_a/in_b       operand pair stream
//   out_valid/out_ready/out_y         result stream
//   write_*, read_*                   one-to-one to the slave method ports
//   done_cnt                          completed transactions (wraps)
//   err                               sticky status-poll timeout
module dut_bus_master
    import dut_bus_pkg::*;
#(
    parameter int POLL_LIMIT = 64,
    parameter int CNT_W      = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_a,
    input  logic             in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_y,
    output logic [2:0]       write_address,
    output logic             write_data,
    output logic             write_en,
    input  logic             write_rdy,
    output logic [2:0]       read_address,
    output logic             read_en,
    input  logic             read_data,
    input  logic             read_rdy,
    output logic [CNT_W-1:0] done_cnt,
    output logic             err
);

    localparam int             PCW       = $clog2(POLL_LIMIT + 1);
    localparam logic [PCW-1:0] POLL_LAST = PCW'(POLL_LIMIT - 1);

    state_t         state;
    state_t         state_next;
    logic           a_lat;
    logic           b_lat;
    logic [PCW-1:0] poll_cnt;
    logic           poll_inc;
    logic           poll_enter;
    logic           wr_req_next;
    logic           rd_req_next;
    logic [2:0]     addr_next;
    logic           data_next;

    always_ff @(posedge CLK or posedge RST_N) begin
        if (RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        poll_inc   = 1'b0;
        case (state)
            IDLE: if (in_valid) state_next = POLL_A;
            POLL_A, POLL_B, POLL_Y: begin
                // Only reads the slave actually accepted count toward the limit.
                if (read_en) begin
                    if (read_data) begin
                        case (state)
                            POLL_A:  state_next = WR_A;
                            POLL_B:  state_next = WR_B;
                            default: state_next = RD_Y;
                        endcase
                    end else if (poll_cnt == POLL_LAST) begin
                        state_next = ERR;
                    end else begin
                        poll_inc = 1'b1;
                    end
                end
            end
            WR_A:    if (write_en) state_next = POLL_B;
            WR_B:    if (write_en) state_next = POLL_Y;
            RD_Y:    if (read_en) state_next = OUT;
            OUT:     if (out_ready) state_next = IDLE;
            ERR:     state_next = ERR;
            default: state_next = IDLE;
        endcase
    end

    assign poll_enter = (state_next inside {POLL_A, POLL_B, POLL_Y}) && (state_next != state);

    // Bus request for the cycle after this edge is decoded from the next state,
    // so the port flops line up with the state they serve.
    always_comb begin
        wr_req_next = 1'b0;
        rd_req_next = 1'b0;
        addr_next   = ADDR_A_STATUS;
        data_next   = 1'b0;
        case (state_next)
            POLL_A: begin rd_req_next = 1'b1; addr_next = ADDR_A_STATUS; end
            WR_A:   begin wr_req_next = 1'b1; addr_next = ADDR_A_DATA; data_next = a_lat; end
            POLL_B: begin rd_req_next = 1'b1; addr_next = ADDR_B_STATUS; end
            WR_B:   begin wr_req_next = 1'b1; addr_next = ADDR_B_DATA; data_next = b_lat; end
            POLL_Y: begin rd_req_next = 1'b1; addr_next = ADDR_Y_STATUS; end
            RD_Y:   begin rd_req_next = 1'b1; addr_next = ADDR_Y_OUTPUT; end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST_N) begin
        if (RST_N) begin
            a_lat     <= 1'b0;
            b_lat     <= 1'b0;
            poll_cnt  <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_y     <= 1'b0;
            done_cnt  <= '0;
            err       <= 1'b0;
        end else begin
            in_ready  <= (state_next == IDLE);
            out_valid <= (state_next == OUT);
            if (state_next == ERR) err <= 1'b1;
            if (state == IDLE && in_valid) begin
                a_lat <= in_a;
                b_lat <= in_b;
            end
            if (poll_enter) begin
                poll_cnt <= '0;
            end else if (poll_inc) begin
                poll_cnt <= poll_cnt + 1'b1;
            end
            if (state == RD_Y && read_en) out_y <= read_data;
            if (state == OUT && out_ready) done_cnt <= done_cnt + 1'b1;
        end
    end

    dut_bus_port u_port (
        .clk           (CLK),
        .rst           (RST_N),
        .wr_req_next   (wr_req_next),
        .rd_req_next   (rd_req_next),
        .addr_next     (addr_next),
        .data_next     (data_next),
        .write_rdy     (write_rdy),
        .read_rdy      (read_rdy),
        .write_address (write_address),
        .write_data    (write_data),
        .write_en      (write_en),
        .read_address  (read_address),
        .read_en       (read_en)
    );

endmodule
